// File: rtl/tlb_maint_ctrl.sv
// tlb_maint_ctrl: sequences TLB maintenance ops (SRCH, RD, WR, FILL, INV)
// onto the TLB's single write port. One op is in flight at a time. SRCH and
// INV scan one entry per cycle against the live entry array.
//
// Entry layout (ENTRY_W bits, payload above ps is carried opaquely):
//   [0] e | [1] g | [11:2] asid | [30:12] vppn | [36:31] ps | [ENTRY_W-1:37] payload
//
// Ports:
//   clk, rst                  clock, async active-high reset
//   req_valid/req_ready       request handshake (ready only when idle)
//   req_op                    0 SRCH, 1 RD, 2 WR, 3 FILL, 4 INV, 5-7 illegal
//   req_inv_op/asid/va/idx/entry  request operands, latched at acceptance
//   tlb_entries               flattened live TLB contents, entry i at [i*ENTRY_W +: ENTRY_W]
//   we/wr_idx/wr_entry        TLB write port
//   done                      one-cycle completion pulse
//   rsp_hit/idx/entry/err     result, valid with done and held until next done.
//                             Fields not produced by an op read as 0 (rsp_idx=0 on
//                             SRCH miss, INV and ERR).
module tlb_maint_ctrl #(
  parameter int TLB_ENTRY_NUM = 16,
  parameter int TLB_IDX_WID   = $clog2(TLB_ENTRY_NUM),
  parameter int ENTRY_W       = 57
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               req_valid,
  output logic                               req_ready,
  input  logic [2:0]                         req_op,
  input  logic [4:0]                         req_inv_op,
  input  logic [9:0]                         req_asid,
  input  logic [31:0]                        req_va,
  input  logic [TLB_IDX_WID-1:0]             req_idx,
  input  logic [ENTRY_W-1:0]                 req_entry,
  input  logic [TLB_ENTRY_NUM*ENTRY_W-1:0]   tlb_entries,
  output logic                               we,
  output logic [TLB_IDX_WID-1:0]             wr_idx,
  output logic [ENTRY_W-1:0]                 wr_entry,
  output logic                               done,
  output logic                               rsp_hit,
  output logic [TLB_IDX_WID-1:0]             rsp_idx,
  output logic [ENTRY_W-1:0]                 rsp_entry,
  output logic                               rsp_err
);

  typedef enum logic [2:0] {S_IDLE, S_RD, S_WR, S_SRCH, S_INV, S_ERR} state_t;

  state_t                   state_q, state_d;
  logic [TLB_IDX_WID-1:0]   k_q, k_d;
  logic [TLB_IDX_WID-1:0]   fill_ptr_q, fill_ptr_d;
  logic                     fill_q, fill_d;
  logic [4:0]               inv_op_q, inv_op_d;
  logic [9:0]               asid_q, asid_d;
  logic [18:0]              vppn_q, vppn_d;
  logic [TLB_IDX_WID-1:0]   idx_q, idx_d;
  logic [ENTRY_W-1:0]       entry_q, entry_d;
  logic                     rsp_hit_q, rsp_hit_d;
  logic [TLB_IDX_WID-1:0]   rsp_idx_q, rsp_idx_d;
  logic [ENTRY_W-1:0]       rsp_entry_q, rsp_entry_d;
  logic                     rsp_err_q, rsp_err_d;

  logic                     nxt_hit, nxt_err;
  logic [TLB_IDX_WID-1:0]   nxt_idx;
  logic [ENTRY_W-1:0]       nxt_entry;

  logic [ENTRY_W-1:0]       ent [TLB_ENTRY_NUM];
  logic [ENTRY_W-1:0]       cur;
  logic                     cur_e, cur_g, asid_eq, vppn_eq, srch_hit, inv_cond, last_k;

  logic                     unused_va;
  assign unused_va = ^req_va[12:0];

  always_comb begin
    for (int i = 0; i < TLB_ENTRY_NUM; i++) begin
      ent[i] = tlb_entries[i*ENTRY_W +: ENTRY_W];
    end
  end

  // Entry under scan; writes only ever target already-scanned indices.
  assign cur     = ent[k_q];
  assign cur_e   = cur[0];
  assign cur_g   = cur[1];
  assign asid_eq = (cur[11:2] == asid_q);
  // 2 MB pages (ps=21) ignore the low 9 vppn bits.
  assign vppn_eq = (cur[36:31] == 6'd21) ? (cur[30:21] == vppn_q[18:9])
                                         : (cur[30:12] == vppn_q);
  assign srch_hit = cur_e && (cur_g || asid_eq) && vppn_eq;
  assign last_k   = &k_q;

  always_comb begin
    case (inv_op_q)
      5'd0, 5'd1: inv_cond = 1'b1;
      5'd2:       inv_cond = cur_g;
      5'd3:       inv_cond = !cur_g;
      5'd4:       inv_cond = !cur_g && asid_eq;
      5'd5:       inv_cond = !cur_g && asid_eq && vppn_eq;
      5'd6:       inv_cond = (cur_g || asid_eq) && vppn_eq;
      default:    inv_cond = 1'b0;
    endcase
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          case (req_op)
            3'd0:       state_d = S_SRCH;
            3'd1:       state_d = S_RD;
            3'd2, 3'd3: state_d = S_WR;
            3'd4:       state_d = (req_inv_op > 5'd6) ? S_ERR : S_INV;
            default:    state_d = S_ERR;
          endcase
        end
      end
      S_SRCH:  if (srch_hit || last_k) state_d = S_IDLE;
      S_INV:   if (last_k) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs
  always_comb begin
    req_ready = 1'b0;
    we        = 1'b0;
    wr_idx    = '0;
    wr_entry  = '0;
    done      = 1'b0;
    nxt_hit   = 1'b0;
    nxt_idx   = '0;
    nxt_entry = '0;
    nxt_err   = 1'b0;
    case (state_q)
      S_IDLE: req_ready = 1'b1;
      S_RD: begin
        done      = 1'b1;
        nxt_idx   = idx_q;
        nxt_entry = ent[idx_q];
      end
      S_WR: begin
        we       = 1'b1;
        wr_idx   = fill_q ? fill_ptr_q : idx_q;
        wr_entry = entry_q;
        done     = 1'b1;
        nxt_idx  = wr_idx;
      end
      S_SRCH: begin
        done    = srch_hit || last_k;
        nxt_hit = srch_hit;
        nxt_idx = srch_hit ? k_q : '0;
      end
      S_INV: begin
        we       = cur_e && inv_cond;
        wr_idx   = k_q;
        wr_entry = {cur[ENTRY_W-1:1], 1'b0};
        done     = last_k;
      end
      S_ERR: begin
        done    = 1'b1;
        nxt_err = 1'b1;
      end
      default: ;
    endcase
  end

  assign rsp_hit   = rsp_hit_d;
  assign rsp_idx   = rsp_idx_d;
  assign rsp_entry = rsp_entry_d;
  assign rsp_err   = rsp_err_d;

  always_comb begin
    fill_d      = fill_q;
    inv_op_d    = inv_op_q;
    asid_d      = asid_q;
    vppn_d      = vppn_q;
    idx_d       = idx_q;
    entry_d     = entry_q;
    k_d         = k_q;
    fill_ptr_d  = fill_ptr_q;
    rsp_hit_d   = done ? nxt_hit   : rsp_hit_q;
    rsp_idx_d   = done ? nxt_idx   : rsp_idx_q;
    rsp_entry_d = done ? nxt_entry : rsp_entry_q;
    rsp_err_d   = done ? nxt_err   : rsp_err_q;
    if (state_q == S_IDLE && req_valid) begin
      fill_d   = (req_op == 3'd3);
      inv_op_d = req_inv_op;
      asid_d   = req_asid;
      vppn_d   = req_va[31:13];
      idx_d    = req_idx;
      entry_d  = req_entry;
      k_d      = '0;
    end else if (state_q == S_SRCH || state_q == S_INV) begin
      k_d = k_q + 1'b1;
    end
    if (state_q == S_WR && fill_q) begin
      fill_ptr_d = fill_ptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      k_q         <= '0;
      fill_ptr_q  <= '0;
      fill_q      <= 1'b0;
      inv_op_q    <= '0;
      asid_q      <= '0;
      vppn_q      <= '0;
      idx_q       <= '0;
      entry_q     <= '0;
      rsp_hit_q   <= 1'b0;
      rsp_idx_q   <= '0;
      rsp_entry_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      k_q         <= k_d;
      fill_ptr_q  <= fill_ptr_d;
      fill_q      <= fill_d;
      inv_op_q    <= inv_op_d;
      asid_q      <= asid_d;
      vppn_q      <= vppn_d;
      idx_q       <= idx_d;
      entry_q     <= entry_d;
      rsp_hit_q   <= rsp_hit_d;
      rsp_idx_q   <= rsp_idx_d;
      rsp_entry_q <= rsp_entry_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

endmodule
